// File: rtl/recip_sched.sv
// Round-robin scheduler sharing one external combinational reciprocal unit among NUM_REQ lanes.
// Optional build macro RECIP_ZERO_GUARD_EN saturates the result and flags zero operands.
`timescale 1ns/1ps

module recip_sched #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 18,
    parameter int RW      = 36,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    input  logic [NUM_REQ*DW-1:0] i_req_data,
    output logic [NUM_REQ-1:0]    o_req_ready,
    output logic [DW-1:0]         o_recip_data,
    input  logic [RW-1:0]         i_recip_res,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [RW-1:0]         o_rsp_data,
    output logic [IDW-1:0]        o_rsp_id,
    output logic                  o_rsp_divzero,
    output logic                  o_busy
);

    logic           s1_v;
    logic [DW-1:0]  s1_data;
    logic [IDW-1:0] s1_id;
    logic [IDW-1:0] ptr;

    logic           s2_free;
    logic           s1_adv;
    logic           s1_free;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   cand;
    logic           accept;
    logic [DW-1:0]  gnt_data;
    logic [RW-1:0]  rsp_next;

    assign s2_free = ~o_rsp_valid | i_rsp_ready;
    assign s1_adv  = s1_v & s2_free;
    assign s1_free = ~s1_v | s1_adv;

    // Search starts at ptr and wraps; cand is one bit wider so ptr+i cannot overflow.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NUM_REQ))
                cand = cand - (IDW+1)'(NUM_REQ);
            if (!gnt_found && i_req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    assign o_req_ready = (s1_free && gnt_found) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign accept      = s1_free & gnt_found;
    assign gnt_data    = i_req_data[gnt_idx*DW +: DW];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_id   <= '0;
            ptr     <= '0;
        end else if (accept) begin
            s1_v    <= 1'b1;
            s1_data <= gnt_data;
            s1_id   <= gnt_idx;
            ptr     <= (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + IDW'(1);
        end else begin
            s1_v    <= s1_v & ~s1_adv;
        end
    end

    assign o_recip_data = s1_data;

`ifdef RECIP_ZERO_GUARD_EN
    logic s1_zero;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            s1_zero <= 1'b0;
        else if (accept)
            s1_zero <= (gnt_data == '0);
    end

    assign rsp_next = s1_zero ? {RW{1'b1}} : i_recip_res;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_rsp_divzero <= 1'b0;
        else if (s1_adv)
            o_rsp_divzero <= s1_zero;
    end
`else
    assign rsp_next      = i_recip_res;
    assign o_rsp_divzero = 1'b0;
`endif

    // Output register holds while the consumer stalls, so data/id stay stable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_id    <= '0;
        end else if (s1_adv) begin
            o_rsp_valid <= 1'b1;
            o_rsp_data  <= rsp_next;
            o_rsp_id    <= s1_id;
        end else if (s2_free) begin
            o_rsp_valid <= 1'b0;
        end
    end

    assign o_busy = s1_v | o_rsp_valid;

endmodule
